dshot_rx: RTL and testbench



---
 rtl/dshot_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/dshot_rx.sv | 188 ++++++++++++++++++
 tb/tb_dshot_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dshot_pkg.sv
// Shared DSHOT definitions: frame layout, CRC helper and receiver state type.
package dshot_pkg;

  localparam int unsigned DSHOT_FRAME_BITS = 16;
  localparam int unsigned DSHOT_THR_W      = 11;
  localparam int unsigned DSHOT_CRC_W      = 4;
  localparam int unsigned DSHOT_PAYLOAD_W  = DSHOT_THR_W + 1;

  typedef struct packed {
    logic [DSHOT_THR_W-1:0] throttle;
    logic                   telem;
    logic [DSHOT_CRC_W-1:0] crc;
  } dshot_frame_t;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, CHECK} dshot_rx_state_t;

  // Nibble-wise XOR of the 12-bit payload (throttle + telemetry).
  function automatic logic [DSHOT_CRC_W-1:0] dshot_crc(input logic [DSHOT_PAYLOAD_W-1:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dshot_rx.sv
// DSHOT frame receiver: pulse-width bit decode, gap framing and CRC check.
// Define DSHOT_RX_BIDIR_EN for bidirectional DSHOT (idle-high line, inverted CRC).
module dshot_rx
  import dshot_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 72_000_000,
  parameter int unsigned DSHOT_KBPS  = 600
) (
  input  logic                   i_sys_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_line,
  output logic                   o_valid,
  output logic [DSHOT_THR_W-1:0] o_throttle,
  output logic                   o_telem,
  output logic                   o_crc_err,
  output logic                   o_frame_err,
  output logic                   o_busy
);

  localparam int unsigned BIT_CLKS = CLK_FREQ_HZ / (DSHOT_KBPS * 1000);
  localparam int unsigned GAP_CLKS = 2 * BIT_CLKS;
  localparam int unsigned CNT_W    = $clog2(GAP_CLKS + 1);
  localparam int unsigned BC_W     = $clog2(DSHOT_FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] GAP_MAX    = CNT_W'(GAP_CLKS);
  localparam logic [CNT_W-1:0] ONE_MIN    = CNT_W'(BIT_CLKS / 2);
  localparam logic [CNT_W-1:0] GLITCH_MAX = CNT_W'(BIT_CLKS / 8);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'((3 * BIT_CLKS) / 2 - 1);
  localparam logic [BC_W-1:0]  BITS_FULL  = BC_W'(DSHOT_FRAME_BITS);

`ifdef DSHOT_RX_BIDIR_EN
  localparam logic                   IDLE_LVL = 1'b1;
  localparam logic [DSHOT_CRC_W-1:0] CRC_XOR  = 4'hF;
`else
  localparam logic                   IDLE_LVL = 1'b0;
  localparam logic [DSHOT_CRC_W-1:0] CRC_XOR  = 4'h0;
`endif

  logic line_s;

  sync_2ff #(
    .RST_VAL (IDLE_LVL)
  ) u_sync (
    .clk_i (i_sys_clk),
    .rst_i (i_rst),
    .d_i   (i_line),
    .q_o   (line_s)
  );

  dshot_rx_state_t              state_q;
  logic                         act_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             gap_q;
  logic [CNT_W-1:0]             gap_d;
  logic [BC_W-1:0]              bit_cnt_q;
  logic [DSHOT_FRAME_BITS-1:0]  shreg_q;
  logic                         valid_q;
  logic                         crc_err_q;
  logic                         frame_err_q;
  logic                         busy_q;
  logic [DSHOT_THR_W-1:0]       throttle_q;
  logic                         telem_q;

  logic         act_c;
  logic         act_rise_c;
  logic         act_fall_c;
  logic         gap_armed_c;
  logic         crc_ok_c;
  dshot_frame_t frame_c;

  // Line polarity folding, edge detect and the consecutive-inactive gap counter.
  always_comb begin
    act_c       = line_s ^ IDLE_LVL;
    act_rise_c  = act_c & ~act_q;
    act_fall_c  = ~act_c & act_q;
    gap_armed_c = (gap_q == GAP_MAX);
    frame_c     = shreg_q;
    crc_ok_c    = ((dshot_crc({frame_c.throttle, frame_c.telem}) ^ CRC_XOR) == frame_c.crc);
    gap_d       = gap_q;
    if (act_c || (state_q == CHECK)) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      act_q       <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      valid_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      throttle_q  <= '0;
      telem_q     <= 1'b0;
    end else begin
      act_q       <= act_c;
      gap_q       <= gap_d;
      valid_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (!i_enable) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        cnt_q     <= '0;
        bit_cnt_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (act_rise_c && gap_armed_c) begin
              state_q   <= HIGH;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              bit_cnt_q <= '0;
            end
          end
          HIGH: begin
            if (act_fall_c) begin
              if (cnt_q < GLITCH_MAX) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                frame_err_q <= 1'b1;
              end else begin
                shreg_q   <= {shreg_q[DSHOT_FRAME_BITS-2:0], (cnt_q >= ONE_MIN)};
                bit_cnt_q <= bit_cnt_q + BC_W'(1);
                cnt_q     <= '0;
                state_q   <= LOW;
              end
            end else if (cnt_q == HIGH_LAST) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          LOW: begin
            // Results are registered on entry so the strobe is high during CHECK.
            if (bit_cnt_q == BITS_FULL) begin
              state_q <= CHECK;
              if (crc_ok_c) begin
                valid_q    <= 1'b1;
                throttle_q <= frame_c.throttle;
                telem_q    <= frame_c.telem;
              end else begin
                crc_err_q <= 1'b1;
              end
            end else if (act_rise_c) begin
              state_q <= HIGH;
              cnt_q   <= '0;
            end else if (cnt_q == LOW_LAST) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          CHECK: begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_valid     = valid_q;
  assign o_throttle  = throttle_q;
  assign o_telem     = telem_q;
  assign o_crc_err   = crc_err_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_dshot_rx.sv
// Bench for dshot_rx: frame table plus hand sequences for latency, timeouts, glitches and enable.
// Add +define+DSHOT_RX_BIDIR_EN to run the same checks on the inverted-line variant.
module tb_dshot_rx;

`ifdef DSHOT_RX_BIDIR_EN
  localparam logic        IDLE_LVL = 1'b1;
  localparam logic [15:0] GOOD_F   = 16'h82C9;
  localparam logic [15:0] ALT_F    = 16'h0618;
  localparam logic [15:0] ONES_F   = 16'hFFF0;
  localparam logic [15:0] ZERO_F   = 16'h000F;
`else
  localparam logic        IDLE_LVL = 1'b0;
  localparam logic [15:0] GOOD_F   = 16'h82C6;
  localparam logic [15:0] ALT_F    = 16'h0617;
  localparam logic [15:0] ONES_F   = 16'hFFFF;
  localparam logic [15:0] ZERO_F   = 16'h0000;
`endif
  localparam logic [15:0] BAD_F = 16'h82C5;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        line;
  logic        valid;
  logic [10:0] thr;
  logic        telem;
  logic        crc_err;
  logic        frame_err;
  logic        busy;

  dshot_rx #(
    .CLK_FREQ_HZ (72_000_000),
    .DSHOT_KBPS  (600)
  ) dut (
    .i_sys_clk   (clk),
    .i_rst       (rst),
    .i_enable    (en),
    .i_line      (line),
    .o_valid     (valid),
    .o_throttle  (thr),
    .o_telem     (telem),
    .o_crc_err   (crc_err),
    .o_frame_err (frame_err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_crc = 0;
  int n_ferr = 0;
  int n_mutex = 0;
  int b_valid, b_crc, b_ferr;

  // Strobe counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid)     n_valid++;
    if (crc_err)   n_crc++;
    if (frame_err) n_ferr++;
    if ((int'(valid) + int'(crc_err) + int'(frame_err)) > 1) n_mutex++;
  end

  typedef struct {
    logic [15:0] frame;
    int          pre;
    int          exp_valid;
    int          exp_crc;
    int          exp_thr;
    int          exp_telem;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic act);
    line = act ^ IDLE_LVL;
  endtask

  task automatic idle(input int n);
    drive(1'b0);
    tick(n);
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1);
    tick(b ? 90 : 45);
    drive(1'b0);
    tick(b ? 30 : 75);
  endtask

  task automatic send_bits(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[15-i]);
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_crc   = n_crc;
    b_ferr  = n_ferr;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{GOOD_F, 300, 1, 0, 1046, 0};
    vecs[1] = '{ALT_F,  250, 1, 0, 48,   1};
    vecs[2] = '{ALT_F,  250, 1, 0, 48,   1};
    vecs[3] = '{BAD_F,  250, 0, 1, 48,   1};
    vecs[4] = '{ONES_F, 250, 1, 0, 2047, 1};
    vecs[5] = '{ZERO_F, 250, 1, 0, 0,    0};

    rst = 1'b1;
    en  = 1'b1;
    drive(1'b0);
    tick(4);
    rst = 1'b0;
    tick(1);
    check("reset valid",     int'(valid),     0);
    check("reset throttle",  int'(thr),       0);
    check("reset telem",     int'(telem),     0);
    check("reset crc_err",   int'(crc_err),   0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset busy",      int'(busy),      0);

    for (int k = 0; k < 6; k++) begin
      idle(vecs[k].pre);
      snap();
      send_bits(vecs[k].frame, 16);
      idle(20);
      check($sformatf("vec%0d valid count", k), n_valid - b_valid, vecs[k].exp_valid);
      check($sformatf("vec%0d crc_err count", k), n_crc - b_crc, vecs[k].exp_crc);
      check($sformatf("vec%0d frame_err count", k), n_ferr - b_ferr, 0);
      check($sformatf("vec%0d throttle", k), int'(thr), vecs[k].exp_thr);
      check($sformatf("vec%0d telem", k), int'(telem), vecs[k].exp_telem);
      check($sformatf("vec%0d busy", k), int'(busy), 0);
    end

    // Valid strobe lands exactly two clocks after the synchronized final falling edge.
    idle(300);
    send_bits(GOOD_F, 15);
    drive(1'b1);
    tick(GOOD_F[0] ? 90 : 45);
    drive(1'b0);
    tick(3);
    check("latency valid early", int'(valid), 0);
    tick(1);
    check("latency valid on time", int'(valid), 1);
    tick(1);
    check("latency valid one cycle", int'(valid), 0);
    idle(80);

    // Truncated frame: low timeout fires after 180 low clocks, then recovery.
    idle(300);
    snap();
    send_bits(GOOD_F, 7);
    drive(1'b1);
    tick(45);
    drive(1'b0);
    tick(182);
    check("low timeout early", int'(frame_err), 0);
    tick(1);
    check("low timeout strobe", int'(frame_err), 1);
    tick(1);
    check("low timeout busy", int'(busy), 0);
    idle(100);
    send_bits(GOOD_F, 16);
    idle(20);
    check("trunc frame_err count", n_ferr - b_ferr, 1);
    check("trunc recovery valid", n_valid - b_valid, 1);
    check("trunc recovery throttle", int'(thr), 1046);

    // Short glitch after an armed gap errors; a glitch before rearm is ignored.
    idle(300);
    snap();
    drive(1'b1);
    tick(10);
    drive(1'b0);
    idle(100);
    drive(1'b1);
    tick(4);
    idle(20);
    check("glitch frame_err count", n_ferr - b_ferr, 1);
    check("glitch valid count", n_valid - b_valid, 0);
    check("glitch crc_err count", n_crc - b_crc, 0);

    // Stuck-active line errors once the pulse reaches a full bit time.
    idle(300);
    snap();
    drive(1'b1);
    tick(150);
    idle(20);
    check("stuck frame_err count", n_ferr - b_ferr, 1);
    check("stuck valid count", n_valid - b_valid, 0);

    // Enable drop mid-frame aborts silently; next frame decodes.
    idle(300);
    snap();
    send_bits(GOOD_F, 9);
    en = 1'b0;
    tick(2);
    check("disable busy", int'(busy), 0);
    tick(3);
    en = 1'b1;
    send_bits({GOOD_F[6:0], 9'd0}, 7);
    idle(20);
    check("abort valid count", n_valid - b_valid, 0);
    check("abort crc_err count", n_crc - b_crc, 0);
    check("abort frame_err count", n_ferr - b_ferr, 0);
    idle(300);
    send_bits(ALT_F, 16);
    idle(20);
    check("post-enable valid count", n_valid - b_valid, 1);
    check("post-enable throttle", int'(thr), 48);
    check("post-enable telem", int'(telem), 1);

    // Reset mid-frame clears held results.
    idle(300);
    send_bits(GOOD_F, 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    drive(1'b0);
    check("midframe reset throttle", int'(thr), 0);
    check("midframe reset telem", int'(telem), 0);
    check("midframe reset busy", int'(busy), 0);
    idle(20);

    check("strobe exclusivity", n_mutex, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
